i2c_master_burst: RTL and testbench

Parametrised I2C master that runs a complete multi-byte transaction from a single `trigger`: START, 7-bit address plus R/W, N data bytes with ACK handling, then STOP. It replaces the single-byte `i2c_master_fsm` in the I2C subsystem and adds several features: a programmable SCL divider, burst length, slave-NACK detection, a per-byte write-data request handshake, and asynchronous reset. It sits between the host-side control logic and the open-drain I2C pads.

---
 rtl/i2c_master_burst_if.sv | 27 ++
 rtl/i2c_master_burst.sv | 230 +++++++++++++++++++++++
 tb/tb_i2c_master_burst.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_burst_if.sv
// Host-side control bundle of the burst I2C master: trigger/config in, status and data out.
// The controller binds the "slave" modport, the host logic binds "master".
interface i2c_master_burst_if #(
    parameter int NB_W = 5
);
    logic            trigger;
    logic [6:0]      address;
    logic            rw;
    logic [NB_W-1:0] nbytes;
    logic [7:0]      din;
    logic            din_req;
    logic [7:0]      dout;
    logic            dout_valid;
    logic            busy;
    logic            done;
    logic            nack;

    modport master (
        output trigger, address, rw, nbytes, din,
        input  din_req, dout, dout_valid, busy, done, nack
    );

    modport slave (
        input  trigger, address, rw, nbytes, din,
        output din_req, dout, dout_valid, busy, done, nack
    );
endinterface

// File: rtl/i2c_master_burst.sv
// Burst I2C master: START, address+R/W, N data bytes with ACK handling, STOP, from one trigger.
// Each bit spends four CLK_DIV-long quarters; SCL is high in quarters 2 and 3.
module i2c_master_burst #(
    parameter int CLK_DIV   = 250,
    parameter int MAX_BYTES = 16,
    parameter int NB_W      = $clog2(MAX_BYTES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    i2c_master_burst_if.slave ctrl,
    inout  wire               sda,
    output logic              sclk
);
    localparam int QC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP
    } state_t;

    state_t            state_reg, state_next;
    logic [QC_W-1:0]   qcnt_reg, qcnt_next;
    logic [1:0]        quarter_reg, quarter_next;
    logic [2:0]        bit_reg, bit_next;
    logic [NB_W-1:0]   byte_reg, byte_next;
    logic [NB_W-1:0]   nbytes_reg, nbytes_next;
    logic              rw_reg, rw_next;
    logic [7:0]        shift_reg, shift_next;
    logic [7:0]        byte0_reg, byte0_next;
    logic [7:0]        dout_reg, dout_next;
    logic              dout_valid_reg, dout_valid_next;
    logic              din_req_reg, din_req_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              nack_reg, nack_next;
    logic              ack_smp_reg, ack_smp_next;
    logic [1:0]        sda_sync_reg;

    logic tick, smp_tick, bit_end, last_byte, sda_in, sda_low;

    assign tick      = busy_reg && (qcnt_reg == QC_W'(CLK_DIV - 1));
    assign smp_tick  = tick && (quarter_reg == 2'd2);
    assign bit_end   = tick && (quarter_reg == 2'd3);
    assign last_byte = ((byte_reg + NB_W'(1)) == nbytes_reg);
    assign sda_in    = sda_sync_reg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            qcnt_reg       <= '0;
            quarter_reg    <= 2'd0;
            bit_reg        <= 3'd0;
            byte_reg       <= '0;
            nbytes_reg     <= '0;
            rw_reg         <= 1'b0;
            shift_reg      <= 8'h00;
            byte0_reg      <= 8'h00;
            dout_reg       <= 8'h00;
            dout_valid_reg <= 1'b0;
            din_req_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            nack_reg       <= 1'b0;
            ack_smp_reg    <= 1'b1;
            sda_sync_reg   <= 2'b11;
        end else begin
            state_reg      <= state_next;
            qcnt_reg       <= qcnt_next;
            quarter_reg    <= quarter_next;
            bit_reg        <= bit_next;
            byte_reg       <= byte_next;
            nbytes_reg     <= nbytes_next;
            rw_reg         <= rw_next;
            shift_reg      <= shift_next;
            byte0_reg      <= byte0_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            din_req_reg    <= din_req_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            nack_reg       <= nack_next;
            ack_smp_reg    <= ack_smp_next;
            sda_sync_reg   <= {sda_sync_reg[0], sda};
        end
    end

    always_comb begin
        state_next      = state_reg;
        qcnt_next       = busy_reg ? (tick ? '0 : qcnt_reg + QC_W'(1)) : '0;
        quarter_next    = tick ? quarter_reg + 2'd1 : quarter_reg;
        bit_next        = bit_reg;
        byte_next       = byte_reg;
        nbytes_next     = nbytes_reg;
        rw_next         = rw_reg;
        shift_next      = shift_reg;
        byte0_next      = byte0_reg;
        dout_next       = dout_reg;
        dout_valid_next = 1'b0;
        din_req_next    = 1'b0;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        nack_next       = nack_reg;
        ack_smp_next    = ack_smp_reg;

        case (state_reg)
            IDLE: begin
                if (ctrl.trigger) begin
                    state_next  = START;
                    busy_next   = 1'b1;
                    nack_next   = 1'b0;
                    rw_next     = ctrl.rw;
                    shift_next  = {ctrl.address, ctrl.rw};
                    byte0_next  = ctrl.din;
                    byte_next   = '0;
                    bit_next    = 3'd0;
                    nbytes_next = (ctrl.nbytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : ctrl.nbytes;
                end
            end
            START: begin
                if (bit_end) state_next = ADDR;
            end
            ADDR, WDATA: begin
                if (bit_end) begin
                    shift_next = {shift_reg[6:0], 1'b0};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        if (state_reg == ADDR) begin
                            state_next = ADDR_ACK;
                        end else begin
                            state_next   = WACK;
                            din_req_next = !last_byte;
                        end
                    end
                end
            end
            ADDR_ACK, WACK: begin
                if (smp_tick) ack_smp_next = sda_in;
                if (bit_end) begin
                    if (state_reg == WACK) byte_next = byte_reg + NB_W'(1);
                    if (ack_smp_reg) begin
                        nack_next  = 1'b1;
                        state_next = STOP;
                    end else if (state_reg == ADDR_ACK) begin
                        if (nbytes_reg == '0) begin
                            state_next = STOP;
                        end else if (rw_reg) begin
                            state_next = RDATA;
                        end else begin
                            state_next = WDATA;
                            shift_next = byte0_reg;
                        end
                    end else if (last_byte) begin
                        state_next = STOP;
                    end else begin
                        state_next = WDATA;
                        shift_next = ctrl.din;
                    end
                end
            end
            RDATA: begin
                // Shift in at the sample point so the byte is complete by the end of bit 7.
                if (smp_tick) shift_next = {shift_reg[6:0], sda_in};
                if (bit_end) begin
                    bit_next = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next      = RACK;
                        dout_next       = shift_reg;
                        dout_valid_next = 1'b1;
                    end
                end
            end
            RACK: begin
                if (bit_end) begin
                    byte_next  = byte_reg + NB_W'(1);
                    state_next = last_byte ? STOP : RDATA;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // Pad decode: SCL/SDA are pure functions of the registered state and quarter.
    always_comb begin
        sclk    = 1'b1;
        sda_low = 1'b0;
        case (state_reg)
            START: begin
                sclk    = (quarter_reg != 2'd3);
                sda_low = (quarter_reg != 2'd0);
            end
            ADDR, WDATA: begin
                sclk    = quarter_reg[1];
                sda_low = !shift_reg[7];
            end
            ADDR_ACK, WACK, RDATA: begin
                sclk = quarter_reg[1];
            end
            RACK: begin
                sclk    = quarter_reg[1];
                sda_low = !last_byte;
            end
            STOP: begin
                sclk    = (quarter_reg != 2'd0);
                sda_low = (quarter_reg != 2'd3);
            end
            default: begin
                sclk    = 1'b1;
                sda_low = 1'b0;
            end
        endcase
    end

    assign sda = sda_low ? 1'b0 : 1'bz;

    assign ctrl.din_req    = din_req_reg;
    assign ctrl.dout       = dout_reg;
    assign ctrl.dout_valid = dout_valid_reg;
    assign ctrl.busy       = busy_reg;
    assign ctrl.done       = done_reg;
    assign ctrl.nack       = nack_reg;
endmodule

// File: tb/tb_i2c_master_burst.sv
// Directed bench for i2c_master_burst with a behavioural I2C slave at address 7'h50.
// Bus bytes, ACK bits, handshake pulses and transaction lengths are checked against hand-computed values.
module tb_i2c_master_burst;
    localparam int CLK_DIV   = 4;
    localparam int MAX_BYTES = 16;
    localparam int NB_W      = 5;
    localparam int LIMIT     = 4000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk;
    wire  sda;

    i2c_master_burst_if #(.NB_W(NB_W)) bus();

    i2c_master_burst #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .NB_W(NB_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ctrl (bus),
        .sda  (sda),
        .sclk (sclk)
    );

    always #5 clk = ~clk;

    pullup(sda);

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural slave: ACKs address 7'h50, ACKs write data, returns rdata[] on reads.
    logic       sl_low = 1'b0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic       in_frame = 1'b0, sl_match = 1'b0, sl_rd = 1'b0, sl_sending = 1'b0, sl_mack = 1'b1;
    int         sl_bit = 0, sl_byte = 0;
    logic [7:0] sl_sh = 8'h00, sl_tx = 8'h00;
    logic [7:0] rdata[4];
    logic [7:0] rx_q[$];
    logic       mack_q[$];
    int         start_cnt = 0, stop_cnt = 0;

    assign sda = sl_low ? 1'b0 : 1'bz;

    always @(negedge clk) begin
        prev_scl <= sclk;
        prev_sda <= sda;
        if (!rst_n) begin
            in_frame   <= 1'b0;
            sl_low     <= 1'b0;
            sl_sending <= 1'b0;
            sl_bit     <= 0;
            sl_byte    <= 0;
        end else if (prev_scl && sclk && prev_sda && !sda) begin
            start_cnt  <= start_cnt + 1;
            in_frame   <= 1'b1;
            sl_bit     <= -1;
            sl_byte    <= 0;
            sl_low     <= 1'b0;
            sl_sending <= 1'b0;
        end else if (prev_scl && sclk && !prev_sda && sda) begin
            stop_cnt <= stop_cnt + 1;
            in_frame <= 1'b0;
            sl_low   <= 1'b0;
        end else if (in_frame && !prev_scl && sclk) begin
            if (sl_bit < 8) begin
                sl_sh <= {sl_sh[6:0], sda};
            end else begin
                sl_mack <= sda;
                if (sl_rd && sl_byte > 0) mack_q.push_back(sda);
            end
        end else if (in_frame && prev_scl && !sclk) begin
            if (sl_bit == 7) begin
                rx_q.push_back(sl_sh);
                sl_bit     <= 8;
                sl_sending <= 1'b0;
                if (sl_byte == 0) begin
                    sl_match <= (sl_sh[7:1] == 7'h50);
                    sl_rd    <= sl_sh[0];
                    sl_low   <= (sl_sh[7:1] == 7'h50);
                end else begin
                    sl_low <= sl_match && !sl_rd;
                end
            end else if (sl_bit == 8) begin
                sl_bit  <= 0;
                sl_byte <= sl_byte + 1;
                if (sl_match && sl_rd && (sl_byte == 0 || !sl_mack)) begin
                    sl_tx      <= rdata[sl_byte];
                    sl_low     <= !rdata[sl_byte][7];
                    sl_sending <= 1'b1;
                end else begin
                    sl_low     <= 1'b0;
                    sl_sending <= 1'b0;
                end
            end else begin
                sl_bit <= sl_bit + 1;
                if (sl_sending) sl_low <= !sl_tx[6 - sl_bit];
                else            sl_low <= 1'b0;
            end
        end
    end

    logic [7:0] wbytes[4];
    logic [7:0] dv_q[$];
    int         dreq_cnt;

    task automatic check_trace(input string tag, input logic [31:0] exp, input int n);
        check({tag, "_len"}, rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            check(tag, (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'h100, {24'h0, exp[8*(n-1-i) +: 8]});
        end
    endtask

    task automatic run_txn(input logic [6:0] a, input logic r, input int nb, input int glitch_at,
                           output int cycles);
        int widx;
        int s0, p0;
        rx_q.delete();
        mack_q.delete();
        dv_q.delete();
        dreq_cnt = 0;
        s0 = start_cnt;
        p0 = stop_cnt;
        widx = 1;
        bus.address = a;
        bus.rw      = r;
        bus.nbytes  = NB_W'(nb);
        bus.din     = wbytes[0];
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        check("busy_rise", bus.busy, 1'b1);
        check("nack_clear", bus.nack, 1'b0);
        cycles = 0;
        while (!bus.done && cycles < LIMIT) begin
            if (bus.din_req) begin
                bus.din = wbytes[widx];
                widx++;
                dreq_cnt++;
            end
            if (bus.dout_valid) dv_q.push_back(bus.dout);
            if (cycles == glitch_at) begin
                bus.trigger = 1'b1;
                bus.address = 7'h7F;
            end else begin
                bus.trigger = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        bus.trigger = 1'b0;
        check("timeout", bus.done, 1'b1);
        check("busy_at_done", bus.busy, 1'b0);
        check("start_cnt", start_cnt - s0, 1);
        check("stop_cnt", stop_cnt - p0, 1);
        $display("txn addr=%02h rw=%0d nbytes=%0d cycles=%0d bus_bytes=%0d din_req=%0d dout_valid=%0d nack=%0d",
                 a, r, nb, cycles, rx_q.size(), dreq_cnt, dv_q.size(), bus.nack);
    endtask

    initial begin
        int cyc;
        int act;
        int n;
        bus.trigger = 1'b0;
        bus.address = 7'h00;
        bus.rw      = 1'b0;
        bus.nbytes  = '0;
        bus.din     = 8'h00;
        rdata[0] = 8'h5A; rdata[1] = 8'hC3; rdata[2] = 8'h00; rdata[3] = 8'h00;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_sclk", sclk, 1'b1);
        check("rst_sda", sda, 1'b1);
        check("rst_flags", {bus.busy, bus.done, bus.nack, bus.dout_valid, bus.din_req}, 5'b0);
        check("rst_dout", bus.dout, 8'h00);
        rst_n = 1'b1;
        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (!sclk || !sda || bus.busy) act++;
        end
        check("idle_activity", act, 0);
        check("idle_starts", start_cnt, 0);

        // Write 3 bytes
        wbytes[0] = 8'hA5; wbytes[1] = 8'h3C; wbytes[2] = 8'hFF; wbytes[3] = 8'h00;
        run_txn(7'h50, 1'b0, 3, -1, cyc);
        check("wr_cycles", cyc, 608);
        check("wr_din_req", dreq_cnt, 2);
        check("wr_nack", bus.nack, 1'b0);
        check_trace("wr_bus", 32'hA0A53CFF, 4);

        // Read 2 bytes
        run_txn(7'h50, 1'b1, 2, -1, cyc);
        check("rd_cycles", cyc, 464);
        check("rd_dv_cnt", dv_q.size(), 2);
        check("rd_dout0", (dv_q.size() > 0) ? {24'h0, dv_q[0]} : 32'h100, 8'h5A);
        check("rd_dout1", (dv_q.size() > 1) ? {24'h0, dv_q[1]} : 32'h100, 8'hC3);
        check("rd_mack_cnt", mack_q.size(), 2);
        check("rd_mack0", (mack_q.size() > 0) ? {31'h0, mack_q[0]} : 32'h2, 0);
        check("rd_mack1", (mack_q.size() > 1) ? {31'h0, mack_q[1]} : 32'h2, 1);
        check_trace("rd_bus", 32'h00A15AC3, 3);

        // Address NACK
        run_txn(7'h22, 1'b0, 2, -1, cyc);
        check("nk_cycles", cyc, 176);
        check("nk_nack", bus.nack, 1'b1);
        check("nk_din_req", dreq_cnt, 0);
        check_trace("nk_bus", 32'h00000044, 1);
        repeat (20) @(negedge clk);
        check("nk_sticky", bus.nack, 1'b1);

        // Address-only with a trigger pulse while busy
        run_txn(7'h50, 1'b0, 0, 50, cyc);
        check("a0_cycles", cyc, 176);
        check("a0_nack", bus.nack, 1'b0);
        check_trace("a0_bus", 32'h000000A0, 1);
        act = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.busy) act++;
        end
        check("a0_no_retrigger", act, 0);

        // Reset during the third bit of the first read data byte
        bus.address = 7'h50; bus.rw = 1'b1; bus.nbytes = NB_W'(2);
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        n = 0;
        while (!(sl_byte == 1 && sl_bit == 2) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached", (n < LIMIT), 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_sclk", sclk, 1'b1);
        check("mid_busy", bus.busy, 1'b0);
        check("mid_done", bus.done, 1'b0);
        @(negedge clk);
        #1;
        check("mid_sda", sda, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) act++;
        end
        check("mid_quiet", act, 0);

        // Normal transaction after the reset
        wbytes[0] = 8'h81;
        run_txn(7'h50, 1'b0, 1, -1, cyc);
        check("post_cycles", cyc, 320);
        check("post_nack", bus.nack, 1'b0);
        check_trace("post_bus", 32'h0000A081, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
